// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
// Module : gray_pkg
// Brief  : Shared state encoding and bin-to-Gray helper for the Gray datapath.
// Rev    : 1.0  initial release
// ============================================================================
package gray_pkg;

   localparam int c_MAX_WIDTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Operates at the widest legal code; callers zero-extend and truncate.
   function automatic logic [c_MAX_WIDTH-1:0] bin2gray(input logic [c_MAX_WIDTH-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/gray_code_source_if.sv
`default_nettype none
// ============================================================================
// Module : gray_code_source_if
// Brief  : Control inputs, Gray stream handshake and status of the source.
// Rev    : 1.0  initial release
// ============================================================================
interface gray_code_source_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic             en;
   logic             up;
   logic             wrap;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] gray_out;
   logic             gray_valid;
   logic             gray_ready;
   logic             tc;
   logic             done;
   logic             err;

   modport master (
      input  start, en, up, wrap, load, load_val, gray_ready,
      output gray_out, gray_valid, tc, done, err
   );

   modport slave (
      output start, en, up, wrap, load, load_val, gray_ready,
      input  gray_out, gray_valid, tc, done, err
   );
endinterface
`default_nettype wire

// File: rtl/gray_adj_check.sv
`default_nettype none
// ============================================================================
// Module : gray_adj_check
// Brief  : Flags any transferred code that is not one bit from the previous one.
// Rev    : 1.0  initial release
// ============================================================================
module gray_adj_check #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             xfer,
   input  logic [WIDTH-1:0] code,
   output logic             err
);

   logic [WIDTH-1:0] r_prev;
   logic             r_have_prev;
   logic             r_err;
   logic [WIDTH-1:0] w_diff;
   logic             w_bad;

   assign w_diff = code ^ r_prev;
   // A repeated code (en=0 transfer) is not an adjacency violation.
   assign w_bad  = r_have_prev && (w_diff != '0) && ($countones(w_diff) != 1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_prev      <= '0;
         r_have_prev <= 1'b0;
         r_err       <= 1'b0;
      end else if (clear) begin
         r_have_prev <= 1'b0;
      end else if (xfer) begin
         r_prev      <= code;
         r_have_prev <= 1'b1;
         if (w_bad) begin
            r_err <= 1'b1;
         end
      end
   end

   assign err = r_err;

endmodule
`default_nettype wire

// File: rtl/gray_code_source.sv
`default_nettype none
// ============================================================================
// Module : gray_code_source
// Brief  : Up/down binary counter streamed out as registered Gray code.
// Rev    : 1.0  initial release
// ============================================================================
module gray_code_source
   import gray_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   gray_code_source_if.master  bus
);

   localparam logic [WIDTH-1:0] c_ALL_ONES = '1;

   state_t           r_state;
   logic [WIDTH-1:0] r_bin;
   logic [WIDTH-1:0] r_gray;
   logic             r_valid;
   logic             r_tc;
   logic             r_done;

   logic [WIDTH-1:0] w_bin_nxt;
   logic             w_xfer;
   logic             w_step;
   logic             w_at_term;
   logic             w_hold_term;
   logic             w_err;

   assign w_xfer      = r_valid & bus.gray_ready;
   assign w_step      = w_xfer & bus.en;
   // Direction is taken live so a change of up is honoured on this very edge.
   assign w_at_term   = bus.up ? (r_bin == c_ALL_ONES) : (r_bin == '0);
   assign w_hold_term = w_at_term & ~bus.wrap;

   always_comb begin
      w_bin_nxt = r_bin;
      if (bus.load) begin
         w_bin_nxt = bus.load_val;
      end else if ((r_state == ST_RUN) && w_step && !w_hold_term) begin
         w_bin_nxt = bus.up ? (r_bin + WIDTH'(1)) : (r_bin - WIDTH'(1));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_bin   <= '0;
         r_gray  <= '0;
         r_valid <= 1'b0;
         r_tc    <= ~bus.up;
         r_done  <= 1'b0;
      end else begin
         r_bin  <= w_bin_nxt;
         r_gray <= WIDTH'(bin2gray(c_MAX_WIDTH'(w_bin_nxt)));
         r_tc   <= bus.up ? (w_bin_nxt == c_ALL_ONES) : (w_bin_nxt == '0);
         if (bus.load) begin
            r_state <= ST_RUN;
            r_valid <= 1'b1;
            r_done  <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (bus.start) begin
                     r_state <= ST_RUN;
                     r_valid <= 1'b1;
                  end
               end
               ST_RUN: begin
                  if (w_step && w_hold_term) begin
                     r_state <= ST_DONE;
                     r_valid <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
               ST_DONE: begin
                  if (bus.start) begin
                     r_state <= ST_RUN;
                     r_valid <= 1'b1;
                     r_done  <= 1'b0;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_valid <= 1'b0;
                  r_done  <= 1'b0;
               end
            endcase
         end
      end
   end

   gray_adj_check #(
      .WIDTH (WIDTH)
   ) u_adj_check (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (bus.load),
      .xfer  (w_xfer),
      .code  (r_gray),
      .err   (w_err)
   );

   assign bus.gray_out   = r_gray;
   assign bus.gray_valid = r_valid;
   assign bus.tc         = r_tc;
   assign bus.done       = r_done;
   assign bus.err        = w_err;

endmodule
`default_nettype wire

// File: tb/tb_gray_code_source.sv
`default_nettype none
// ============================================================================
// Module : tb_gray_code_source
// Brief  : Self-checking bench: scoreboard for streams, table for terminal stop.
// Rev    : 1.0  initial release
// ============================================================================
module tb_gray_code_source;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   gray_code_source_if #(.WIDTH(4)) bus ();

   gray_code_source #(.WIDTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   logic [3:0] exp_q[$];

   typedef struct {
      logic       load, start, en, up, wrap, ready;
      logic [3:0] lv;
      logic [3:0] gray;
      logic       valid, tc, done;
   } vec_t;
   vec_t vecs[8];

   function automatic logic [3:0] g(input int unsigned b);
      logic [3:0] x;
      x = 4'(b);
      return x ^ (x >> 1);
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic ld, input logic st, input logic e, input logic u,
                         input logic w, input logic r, input logic [3:0] lv);
      bus.load = ld; bus.start = st; bus.en = e; bus.up = u;
      bus.wrap = w; bus.gray_ready = r; bus.load_val = lv;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sb_step(input string name);
      logic [3:0] e;
      tick();
      if (exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: scoreboard empty, got %0h", name, bus.gray_out);
      end else begin
         e = exp_q.pop_front();
         chk(name, 16'(bus.gray_out), 16'(e));
      end
   endtask

   initial begin
      // terminal-stop table: {ld,st,en,up,wrap,rdy,lv} -> {gray,valid,tc,done}
      vecs[0] = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,4'd13, 4'b1011,1'b1,1'b0,1'b0};
      vecs[1] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,4'd0,  4'b1001,1'b1,1'b0,1'b0};
      vecs[2] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,4'd0,  4'b1000,1'b1,1'b1,1'b0};
      vecs[3] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,4'd0,  4'b1000,1'b0,1'b1,1'b1};
      vecs[4] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,4'd0,  4'b1000,1'b0,1'b1,1'b1};
      vecs[5] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,4'd0,  4'b1000,1'b1,1'b1,1'b0};
      vecs[6] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,4'd0,  4'b1000,1'b1,1'b1,1'b0};
      vecs[7] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,  4'b1000,1'b1,1'b0,1'b0};

      // reset values, tc follows up at the reset edge
      rst_n = 1'b0;
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      tick();
      chk("rst_tc_down", 16'(bus.tc), 16'd1);
      bus.up = 1'b1;
      tick();
      chk("rst_tc_up", 16'(bus.tc), 16'd0);
      chk("rst_gray",  16'(bus.gray_out), 16'd0);
      chk("rst_valid", 16'(bus.gray_valid), 16'd0);
      chk("rst_done",  16'(bus.done), 16'd0);
      chk("rst_err",   16'(bus.err), 16'd0);

      // start, then 17 wrapping up-count transfers
      rst_n = 1'b1;
      set_in(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
      tick();
      chk("start_valid", 16'(bus.gray_valid), 16'd1);
      chk("start_gray",  16'(bus.gray_out), 16'd0);
      bus.start = 1'b0;
      for (int i = 1; i <= 17; i++) begin
         exp_q.push_back(g(i % 16));
         sb_step("up_wrap");
      end
      chk("up_wrap_err", 16'(bus.err), 16'd0);

      // consumer stall: code must hold, then resume one step per transfer
      bus.gray_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_gray", 16'(bus.gray_out), 16'(g(1)));
      end
      bus.gray_ready = 1'b1;
      exp_q.push_back(g(2));
      sb_step("resume");
      exp_q.push_back(g(3));
      sb_step("resume");

      // down-count wrap from zero
      set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
      tick();
      chk("down_tc_before", 16'(bus.tc), 16'd1);
      chk("down_gray0", 16'(bus.gray_out), 16'd0);
      bus.load = 1'b0;
      bus.gray_ready = 1'b1;
      exp_q.push_back(4'b1000);
      sb_step("down_wrap");
      chk("down_tc_after", 16'(bus.tc), 16'd0);

      // load beats start in the same cycle
      set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd10);
      tick();
      chk("load_gray", 16'(bus.gray_out), 16'b1111);
      chk("load_valid", 16'(bus.gray_valid), 16'd1);
      bus.load = 1'b0;
      bus.start = 1'b0;
      exp_q.push_back(4'b1110);
      sb_step("after_load");
      exp_q.push_back(4'b1010);
      sb_step("after_load");
      chk("load_err", 16'(bus.err), 16'd0);

      // non-wrapping run to terminal, DONE, restart
      for (int i = 0; i < 8; i++) begin
         set_in(vecs[i].load, vecs[i].start, vecs[i].en, vecs[i].up,
                vecs[i].wrap, vecs[i].ready, vecs[i].lv);
         tick();
         chk($sformatf("term%0d_gray", i),  16'(bus.gray_out),   16'(vecs[i].gray));
         chk($sformatf("term%0d_valid", i), 16'(bus.gray_valid), 16'(vecs[i].valid));
         chk($sformatf("term%0d_tc", i),    16'(bus.tc),         16'(vecs[i].tc));
         chk($sformatf("term%0d_done", i),  16'(bus.done),       16'(vecs[i].done));
      end
      chk("term_err", 16'(bus.err), 16'd0);

      // reset beats load, start and a pending transfer
      set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
      rst_n = 1'b0;
      tick();
      chk("rst2_gray",  16'(bus.gray_out), 16'd0);
      chk("rst2_valid", 16'(bus.gray_valid), 16'd0);
      chk("rst2_tc",    16'(bus.tc), 16'd0);
      chk("rst2_done",  16'(bus.done), 16'd0);
      chk("rst2_err",   16'(bus.err), 16'd0);
      rst_n = 1'b1;
      bus.load = 1'b0;
      tick();
      chk("restart_valid", 16'(bus.gray_valid), 16'd1);
      bus.start = 1'b0;
      exp_q.push_back(g(1));
      sb_step("restart");
      exp_q.push_back(g(2));
      sb_step("restart");
      chk("restart_err", 16'(bus.err), 16'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
